// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side bundle and ID/EX register outputs
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
);
  logic [1:0]        PC_ctrl_i;
  logic [4:0]        EX_ctrl_i;
  logic [1:0]        MEM_ctrl_i;
  logic [1:0]        WB_ctrl_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [REG_W-1:0]  rs_i;
  logic [REG_W-1:0]  rt_i;
  logic [REG_W-1:0]  rd_i;

  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic [4:0]        EX_ctrl_o;
  logic [1:0]        MEM_ctrl_o;
  logic [1:0]        WB_ctrl_o;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [DATA_W-1:0] imm_o;
  logic [REG_W-1:0]  rs_o;
  logic [REG_W-1:0]  rt_o;
  logic [REG_W-1:0]  wr_reg_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  // decode stage: drives the ID bundle, consumes hold/flush and EX-side values
  modport master (
    output PC_ctrl_i, EX_ctrl_i, MEM_ctrl_i, WB_ctrl_i,
    output rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o,
    input  EX_ctrl_o, MEM_ctrl_o, WB_ctrl_o,
    input  rs_data_o, rt_data_o, imm_o, rs_o, rt_o, wr_reg_o, stall_cnt_o
  );

  // pipeline register itself
  modport slave (
    input  PC_ctrl_i, EX_ctrl_i, MEM_ctrl_i, WB_ctrl_i,
    input  rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i,
    output pc_write_o, ifid_write_o, ifid_flush_o,
    output EX_ctrl_o, MEM_ctrl_o, WB_ctrl_o,
    output rs_data_o, rt_data_o, imm_o, rs_o, rt_o, wr_reg_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  id_ex_stage_if.slave bus
);
  localparam logic [1:0] MEM_LOAD = 2'b10;  // MEM_cs=1, MEM_we=0

  logic [4:0]        ex_q;
  logic [1:0]        mem_q;
  logic [1:0]        wb_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  wr_reg_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              hz;
  logic              unused_pc_sel;

  // jump/branch select is consumed by the PC mux, not by this stage
  assign unused_pc_sel = bus.PC_ctrl_i[0];

  // load in EX whose destination (never $0) feeds either ID source operand
  always_comb begin
    hz = (mem_q == MEM_LOAD) && (wr_reg_q != '0) &&
         ((wr_reg_q == bus.rs_i) || (wr_reg_q == bus.rt_i));
  end

  // on a hazard, hold PC and IF/ID and defer any branch flush to the retry
  assign bus.pc_write_o   = ~hz;
  assign bus.ifid_write_o = ~hz;
  assign bus.ifid_flush_o = ~hz & bus.PC_ctrl_i[1];

  assign bus.EX_ctrl_o   = ex_q;
  assign bus.MEM_ctrl_o  = mem_q;
  assign bus.WB_ctrl_o   = wb_q;
  assign bus.rs_data_o   = rs_data_q;
  assign bus.rt_data_o   = rt_data_q;
  assign bus.imm_o       = imm_q;
  assign bus.rs_o        = rs_q;
  assign bus.rt_o        = rt_q;
  assign bus.wr_reg_o    = wr_reg_q;
  assign bus.stall_cnt_o = stall_cnt_q;

  // latch the ID bundle; a hazard replaces the control fields with a NOP bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      wr_reg_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q      <= hz ? 5'b0 : bus.EX_ctrl_i;
      mem_q     <= hz ? 2'b0 : bus.MEM_ctrl_i;
      wb_q      <= hz ? 2'b0 : bus.WB_ctrl_i;
      rs_data_q <= bus.rs_data_i;
      rt_data_q <= bus.rt_data_i;
      imm_q     <= bus.imm_i;
      rs_q      <= bus.rs_i;
      rt_q      <= bus.rt_i;
      wr_reg_q  <= bus.EX_ctrl_i[0] ? bus.rd_i : bus.rt_i;
      if (hz && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage (CNT_W=4 build)
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    bit          chk_all;
    logic        pcw;
    logic        flush;
    logic [4:0]  ex;
    logic [1:0]  mem;
    logic [1:0]  wb;
    logic [4:0]  wr;
    logic [3:0]  cnt;
    logic [31:0] rsd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: every cycle the DUT presents outputs, pop the expectation and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_write", 32'(bus.pc_write_o), 32'(e.pcw));
        chk("ifid_write", 32'(bus.ifid_write_o), 32'(e.pcw));
        chk("ifid_flush", 32'(bus.ifid_flush_o), 32'(e.flush));
        chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(e.cnt));
        if (e.chk_all) begin
          chk("EX_ctrl", 32'(bus.EX_ctrl_o), 32'(e.ex));
          chk("MEM_ctrl", 32'(bus.MEM_ctrl_o), 32'(e.mem));
          chk("WB_ctrl", 32'(bus.WB_ctrl_o), 32'(e.wb));
          chk("wr_reg", 32'(bus.wr_reg_o), 32'(e.wr));
          chk("rs_data", bus.rs_data_o, e.rsd);
        end
      end
    end
  end

  // apply one cycle of ID inputs and queue what must be visible in that cycle
  task automatic step(
    input bit rst_v, input logic [1:0] pc, input logic [4:0] ex,
    input logic [1:0] mem, input logic [1:0] wb,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [31:0] rsd,
    input bit chk_all, input logic pcw, input logic flush,
    input logic [4:0] e_ex, input logic [1:0] e_mem, input logic [1:0] e_wb,
    input logic [4:0] e_wr, input logic [3:0] e_cnt, input logic [31:0] e_rsd);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = rst_v;
    bus.PC_ctrl_i  = pc;
    bus.EX_ctrl_i  = ex;
    bus.MEM_ctrl_i = mem;
    bus.WB_ctrl_i  = wb;
    bus.rs_i       = rs;
    bus.rt_i       = rt;
    bus.rd_i       = rd;
    bus.rs_data_i  = rsd;
    bus.rt_data_i  = rsd ^ 32'hFFFF_0000;
    bus.imm_i      = rsd + 32'd2;
    e.chk_all = chk_all;
    e.pcw     = pcw;
    e.flush   = flush;
    e.ex      = e_ex;
    e.mem     = e_mem;
    e.wb      = e_wb;
    e.wr      = e_wr;
    e.cnt     = e_cnt;
    e.rsd     = e_rsd;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // directed stimulus; registered expectations reflect the previous step's inputs
  initial begin
    logic [3:0] c;
    bus.PC_ctrl_i  = '0;
    bus.EX_ctrl_i  = '0;
    bus.MEM_ctrl_i = '0;
    bus.WB_ctrl_i  = '0;
    bus.rs_i       = '0;
    bus.rt_i       = '0;
    bus.rd_i       = '0;
    bus.rs_data_i  = '0;
    bus.rt_data_i  = '0;
    bus.imm_i      = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    //    rst pc     ex        mem    wb     rs rt rd rsd        all pcw fl e_ex      e_mem  e_wb   wr cnt rsd
    step(0, 2'b00, 5'b00001, 2'b00, 2'b11, 1, 2, 3, 32'h11,   1, 1, 0, 5'b00000, 2'b00, 2'b00, 0, 0, 32'h0);   // reset state, ADD rd=3
    step(0, 2'b00, 5'b00010, 2'b10, 2'b11, 1, 4, 0, 32'h22,   1, 1, 0, 5'b00001, 2'b00, 2'b11, 3, 0, 32'h11);  // LW rt=4
    step(0, 2'b00, 5'b00001, 2'b00, 2'b11, 4, 2, 6, 32'h33,   1, 0, 0, 5'b00010, 2'b10, 2'b11, 4, 0, 32'h22);  // ADD rs=4 -> hazard
    step(0, 2'b00, 5'b00001, 2'b00, 2'b11, 4, 2, 6, 32'h33,   1, 1, 0, 5'b00000, 2'b00, 2'b00, 6, 1, 32'h33);  // bubble, ADD retried
    step(0, 2'b00, 5'b00000, 2'b00, 2'b00, 0, 0, 0, 32'h0,    1, 1, 0, 5'b00001, 2'b00, 2'b11, 6, 1, 32'h33);  // ADD latched
    step(0, 2'b00, 5'b00010, 2'b10, 2'b11, 0, 0, 0, 32'h44,   1, 1, 0, 5'b00000, 2'b00, 2'b00, 0, 1, 32'h0);   // LW rt=0
    step(0, 2'b00, 5'b00001, 2'b00, 2'b11, 0, 0, 7, 32'h55,   1, 1, 0, 5'b00010, 2'b10, 2'b11, 0, 1, 32'h44);  // ADD rs=0: no stall
    step(0, 2'b00, 5'b00010, 2'b10, 2'b11, 0, 5, 0, 32'h66,   1, 1, 0, 5'b00001, 2'b00, 2'b11, 7, 1, 32'h55);  // LW rt=5
    step(0, 2'b11, 5'b00100, 2'b00, 2'b00, 5, 1, 0, 32'h77,   1, 0, 0, 5'b00010, 2'b10, 2'b11, 5, 1, 32'h66);  // BEQ taken: stall, no flush
    step(0, 2'b11, 5'b00100, 2'b00, 2'b00, 5, 1, 0, 32'h77,   1, 1, 1, 5'b00000, 2'b00, 2'b00, 1, 2, 32'h77);  // retry: flush
    step(0, 2'b00, 5'b00000, 2'b00, 2'b00, 0, 0, 0, 32'h0,    1, 1, 0, 5'b00100, 2'b00, 2'b00, 1, 2, 32'h77);  // BEQ ctrl latched

    // drive the counter to saturation and past it
    c = 4'd2;
    for (int i = 0; i < 15; i++) begin
      step(0, 2'b00, 5'b00010, 2'b10, 2'b11, 1, 4, 0, 32'h22, 0, 1, 0, 5'b0, 2'b0, 2'b0, 0, c, 32'h0);
      step(0, 2'b00, 5'b00001, 2'b00, 2'b11, 4, 2, 6, 32'h33, 0, 0, 0, 5'b0, 2'b0, 2'b0, 0, c, 32'h0);
      c = (c == 4'hF) ? 4'hF : c + 4'd1;
      step(0, 2'b00, 5'b00001, 2'b00, 2'b11, 4, 2, 6, 32'h33, 0, 1, 0, 5'b0, 2'b0, 2'b0, 0, c, 32'h0);
    end

    // reset lands on the edge that would have loaded the bubble
    step(0, 2'b00, 5'b00010, 2'b10, 2'b11, 1, 4, 0, 32'h22,   0, 1, 0, 5'b0, 2'b0, 2'b0, 0, 4'hF, 32'h0);
    step(1, 2'b00, 5'b00001, 2'b00, 2'b11, 4, 2, 6, 32'h33,   0, 0, 0, 5'b0, 2'b0, 2'b0, 0, 4'hF, 32'h0);
    step(0, 2'b00, 5'b00001, 2'b00, 2'b11, 4, 2, 6, 32'h33,   1, 1, 0, 5'b00000, 2'b00, 2'b00, 0, 0, 32'h0);
    step(0, 2'b00, 5'b00000, 2'b00, 2'b00, 0, 0, 0, 32'h0,    1, 1, 0, 5'b00001, 2'b00, 2'b11, 6, 0, 32'h33);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
